// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide controller: op encodings,
// controller states and the divider iteration count.
package md_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_e;

    localparam int         DIV_ITERS = 32;
    localparam logic [4:0] CNT_LAST  = 5'(DIV_ITERS - 1);

    // Codes 9-15 behave exactly like NONE.
    function automatic logic is_md_op(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd8);
    endfunction

endpackage

// File: rtl/md_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, shift the quotient bit in.
// The quotient register doubles as the dividend shift register.
module md_div_step (
    input  logic [31:0] rem_i,
    input  logic [31:0] quo_i,
    input  logic [31:0] div_i,
    output logic [31:0] rem_o,
    output logic [31:0] quo_o
);

    logic [32:0] rem_sh;
    logic [32:0] diff;
    logic        fits;

    // trial subtraction on a 33-bit partial remainder so the shift never overflows
    always_comb begin
        rem_sh = {rem_i, quo_i[31]};
        diff   = rem_sh - {1'b0, div_i};
        fits   = (rem_sh >= {1'b0, div_i});
        rem_o  = fits ? diff[31:0] : rem_sh[31:0];
        quo_o  = {quo_i[30:0], fits};
    end

endmodule

// File: rtl/md_ctrl.sv
// HI/LO multiply-divide controller: 2-cycle multiplier, 32-iteration
// restoring divider with a sign-fix cycle, MTHI/MTLO/MFHI/MFLO access.
// Optional macro MD_DIVZERO_FAST_EN: divide by zero skips the iterations
// (IDLE -> FIX -> IDLE) with identical HI/LO results.
module md_ctrl
    import md_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        ex_valid,
    input  logic [3:0]  ex_md_op,
    input  logic [31:0] ex_rs_data,
    input  logic [31:0] ex_rt_data,
    input  logic        ex_flush,
    output logic        md_stall,
    output logic [31:0] md_rdata,
    output logic        md_busy,
    output logic [31:0] hi_q,
    output logic [31:0] lo_q
);

    md_state_e   state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_d, lo_d;
    logic [31:0] a_q, a_d;        // multiplicand / dividend-quotient shift reg
    logic [31:0] b_q, b_d;        // multiplier / divisor
    logic [31:0] rem_q, rem_d;    // partial remainder
    logic        mul_signed_q, mul_signed_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic        dz_q, dz_d;

    logic        op_ok, issue;
    logic        div_signed, rs_neg, rt_neg, rt_zero;
    logic [31:0] rs_abs, rt_abs;
    logic [31:0] step_rem, step_quo;
    logic [63:0] mul_a_ext, mul_b_ext, mul_prod;
    logic [31:0] q_fix, rem_src, r_fix;

    assign op_ok    = is_md_op(ex_md_op);
    assign md_stall = ex_valid & op_ok & ~ex_flush & (state_q != ST_IDLE);
    assign issue    = ex_valid & op_ok & ~ex_flush & ~md_stall;
    assign md_busy  = (state_q != ST_IDLE);

    // divide operand conditioning at issue
    assign div_signed = (ex_md_op == OP_DIV);
    assign rs_neg     = div_signed & ex_rs_data[31];
    assign rt_neg     = div_signed & ex_rt_data[31];
    assign rs_abs     = rs_neg ? (~ex_rs_data + 32'd1) : ex_rs_data;
    assign rt_abs     = rt_neg ? (~ex_rt_data + 32'd1) : ex_rt_data;
    assign rt_zero    = (ex_rt_data == 32'd0);

    md_div_step u_div_step (
        .rem_i (rem_q),
        .quo_i (a_q),
        .div_i (b_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    // low 64 bits of the product are the same for signed and unsigned once extended
    assign mul_a_ext = mul_signed_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    assign mul_b_ext = mul_signed_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    assign mul_prod  = mul_a_ext * mul_b_ext;

    // In the fast zero-divide path no iterations ran, so |rs| still sits in a_q;
    // otherwise dividing by zero leaves |rs| in the remainder.
`ifdef MD_DIVZERO_FAST_EN
    assign rem_src = dz_q ? a_q : rem_q;
`else
    assign rem_src = rem_q;
`endif
    assign q_fix = q_neg_q ? (~a_q + 32'd1) : a_q;
    assign r_fix = r_neg_q ? (~rem_src + 32'd1) : rem_src;

    // read port: current HI/LO, zero when not a read or while stalled
    always_comb begin
        md_rdata = 32'd0;
        if (!md_stall) begin
            if (ex_md_op == OP_MFHI) md_rdata = hi_q;
            if (ex_md_op == OP_MFLO) md_rdata = lo_q;
        end
    end

    // next-state and datapath control
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        a_d          = a_q;
        b_d          = b_q;
        rem_d        = rem_q;
        mul_signed_d = mul_signed_q;
        q_neg_d      = q_neg_q;
        r_neg_d      = r_neg_q;
        dz_d         = dz_q;
        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    case (ex_md_op)
                        OP_MULT, OP_MULTU: begin
                            a_d          = ex_rs_data;
                            b_d          = ex_rt_data;
                            mul_signed_d = (ex_md_op == OP_MULT);
                            cnt_d        = 5'd0;
                            state_d      = ST_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            a_d     = rs_abs;
                            b_d     = rt_abs;
                            rem_d   = 32'd0;
                            q_neg_d = rs_neg ^ rt_neg;
                            r_neg_d = rs_neg;
                            dz_d    = rt_zero;
                            cnt_d   = 5'd0;
                            state_d = ST_DIV;
`ifdef MD_DIVZERO_FAST_EN
                            if (rt_zero) state_d = ST_FIX;
`endif
                        end
                        OP_MTHI: hi_d = ex_rs_data;
                        OP_MTLO: lo_d = ex_rs_data;
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                if (cnt_q == 5'd1) begin
                    hi_d    = mul_prod[63:32];
                    lo_d    = mul_prod[31:0];
                    cnt_d   = 5'd0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            ST_DIV: begin
                a_d   = step_quo;
                rem_d = step_rem;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = 5'd0;
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            ST_FIX: begin
                lo_d    = dz_q ? 32'hFFFF_FFFF : q_fix;
                hi_d    = r_fix;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 5'd0;
            end
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 5'd0;
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
            a_q          <= 32'd0;
            b_q          <= 32'd0;
            rem_q        <= 32'd0;
            mul_signed_q <= 1'b0;
            q_neg_q      <= 1'b0;
            r_neg_q      <= 1'b0;
            dz_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rem_q        <= rem_d;
            mul_signed_q <= mul_signed_d;
            q_neg_q      <= q_neg_d;
            r_neg_q      <= r_neg_d;
            dz_q         <= dz_d;
        end
    end

endmodule
